csc_coef_ctrl: RTL and testbench

CSC_COEF_CTRL -- requirements
Module: csc_coef_ctrl

---
 rtl/csc_pkg.sv | 35 +++
 rtl/csc_coef_rom.sv | 24 ++
 rtl/csc_coef_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_csc_coef_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared definitions for the CSC coefficient controller: register map,
// control-FSM state encoding and the fixed RGB->YCbCr preset tables.
package csc_pkg;

    localparam int unsigned NUM_COEF = 9;
    localparam int unsigned NUM_BIAS = 3;

    localparam logic [3:0] ADDR_COEF_LAST  = 4'd8;
    localparam logic [3:0] ADDR_BIAS_FIRST = 4'd9;
    localparam logic [3:0] ADDR_CTRL       = 4'd12;

    localparam int unsigned CTRL_BYPASS_BIT    = 0;
    localparam int unsigned CTRL_PRESET_EN_BIT = 1;
    localparam int unsigned CTRL_PRESET_ID_BIT = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // Row-major: Y row, Cb row, Cr row; fixed-point scale 512.
    localparam int PRESET_BT601_COEF [NUM_COEF] = '{
        153,  301,   58,
        -86, -170,  256,
        256, -214,  -42
    };
    localparam int PRESET_BT709_COEF [NUM_COEF] = '{
        109,  366,   37,
        -59, -197,  256,
        256, -233,  -23
    };
    localparam int PRESET_BT601_BIAS [NUM_BIAS] = '{0, 0, 0};
    localparam int PRESET_BT709_BIAS [NUM_BIAS] = '{0, 0, 0};

endpackage

// File: rtl/csc_coef_rom.sv
// Combinational preset table lookup: preset_id selects BT.601 (0) or BT.709 (1).
module csc_coef_rom
    import csc_pkg::*;
#(
    parameter int unsigned COEF_WIDTH = 10,
    parameter int unsigned BIAS_WIDTH = 8
) (
    input  logic                         preset_id,
    output logic signed [COEF_WIDTH-1:0] coef [NUM_COEF],
    output logic signed [BIAS_WIDTH-1:0] bias [NUM_BIAS]
);

    always_comb begin
        for (int unsigned i = 0; i < NUM_COEF; i++) begin
            coef[i] = preset_id ? COEF_WIDTH'(PRESET_BT709_COEF[i])
                                : COEF_WIDTH'(PRESET_BT601_COEF[i]);
        end
        for (int unsigned i = 0; i < NUM_BIAS; i++) begin
            bias[i] = preset_id ? BIAS_WIDTH'(PRESET_BT709_BIAS[i])
                                : BIAS_WIDTH'(PRESET_BT601_BIAS[i]);
        end
    end

endmodule

// File: rtl/csc_coef_ctrl.sv
// CSC coefficient controller: shadow register bank written by software,
// applied to the active bank on the first vsync rise after a commit.
module csc_coef_ctrl
    import csc_pkg::*;
#(
    parameter int unsigned COEF_WIDTH  = 10,
    parameter int unsigned BIAS_WIDTH  = 8,
    parameter int unsigned WDATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_wr_en,
    input  logic [3:0]                    i_wr_addr,
    input  logic [WDATA_WIDTH-1:0]        i_wr_data,
    input  logic [3:0]                    i_rd_addr,
    output logic [WDATA_WIDTH-1:0]        o_rd_data,
    input  logic                          i_commit,
    input  logic                          i_vs,
    output logic                          o_pending,
    output logic                          o_update,
    output logic                          o_bypass,
    output logic signed [COEF_WIDTH-1:0]  o_coef00,
    output logic signed [COEF_WIDTH-1:0]  o_coef01,
    output logic signed [COEF_WIDTH-1:0]  o_coef02,
    output logic signed [COEF_WIDTH-1:0]  o_coef10,
    output logic signed [COEF_WIDTH-1:0]  o_coef11,
    output logic signed [COEF_WIDTH-1:0]  o_coef12,
    output logic signed [COEF_WIDTH-1:0]  o_coef20,
    output logic signed [COEF_WIDTH-1:0]  o_coef21,
    output logic signed [COEF_WIDTH-1:0]  o_coef22,
    output logic signed [BIAS_WIDTH-1:0]  o_bias0,
    output logic signed [BIAS_WIDTH-1:0]  o_bias1,
    output logic signed [BIAS_WIDTH-1:0]  o_bias2
);

    state_e state_q, state_d;
    logic   vs_dly_q, vs_dly_d;
    logic   update_q, update_d;
    logic [WDATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic signed [COEF_WIDTH-1:0] coef_sh_q  [NUM_COEF];
    logic signed [COEF_WIDTH-1:0] coef_sh_d  [NUM_COEF];
    logic signed [BIAS_WIDTH-1:0] bias_sh_q  [NUM_BIAS];
    logic signed [BIAS_WIDTH-1:0] bias_sh_d  [NUM_BIAS];
    logic bypass_sh_q, bypass_sh_d;
    logic preset_en_q, preset_en_d;
    logic preset_id_q, preset_id_d;

    logic signed [COEF_WIDTH-1:0] coef_act_q [NUM_COEF];
    logic signed [COEF_WIDTH-1:0] coef_act_d [NUM_COEF];
    logic signed [BIAS_WIDTH-1:0] bias_act_q [NUM_BIAS];
    logic signed [BIAS_WIDTH-1:0] bias_act_d [NUM_BIAS];
    logic bypass_act_q, bypass_act_d;

    logic signed [COEF_WIDTH-1:0] rom_coef [NUM_COEF];
    logic signed [BIAS_WIDTH-1:0] rom_bias [NUM_BIAS];

    logic vs_rise;
    logic apply;
    logic wr_data_unused;

    // Upper write-data bits beyond the widest field are intentionally dropped.
    assign wr_data_unused = ^i_wr_data;

    csc_coef_rom #(
        .COEF_WIDTH (COEF_WIDTH),
        .BIAS_WIDTH (BIAS_WIDTH)
    ) u_rom (
        .preset_id (preset_id_q),
        .coef      (rom_coef),
        .bias      (rom_bias)
    );

    assign vs_rise = i_vs & ~vs_dly_q;
    assign apply   = (state_q == ST_PENDING) && vs_rise;

    always_comb begin
        state_d  = state_q;
        vs_dly_d = i_vs;
        update_d = apply;
        unique case (state_q)
            ST_IDLE:    if (i_commit) state_d = ST_PENDING;
            ST_PENDING: if (vs_rise)  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Shadow writes and active loads both read the current shadow _q, so a
    // write landing in the apply cycle reaches only the shadow bank.
    always_comb begin
        coef_sh_d    = coef_sh_q;
        bias_sh_d    = bias_sh_q;
        bypass_sh_d  = bypass_sh_q;
        preset_en_d  = preset_en_q;
        preset_id_d  = preset_id_q;
        coef_act_d   = coef_act_q;
        bias_act_d   = bias_act_q;
        bypass_act_d = bypass_act_q;

        if (i_wr_en) begin
            for (int unsigned i = 0; i < NUM_COEF; i++) begin
                if (i_wr_addr == 4'(i)) coef_sh_d[i] = i_wr_data[COEF_WIDTH-1:0];
            end
            for (int unsigned i = 0; i < NUM_BIAS; i++) begin
                if (i_wr_addr == 4'(ADDR_BIAS_FIRST + i)) bias_sh_d[i] = i_wr_data[BIAS_WIDTH-1:0];
            end
            if (i_wr_addr == ADDR_CTRL) begin
                bypass_sh_d = i_wr_data[CTRL_BYPASS_BIT];
                preset_en_d = i_wr_data[CTRL_PRESET_EN_BIT];
                preset_id_d = i_wr_data[CTRL_PRESET_ID_BIT];
            end
        end

        if (apply) begin
            bypass_act_d = bypass_sh_q;
            for (int unsigned i = 0; i < NUM_COEF; i++) begin
                coef_act_d[i] = preset_en_q ? rom_coef[i] : coef_sh_q[i];
            end
            for (int unsigned i = 0; i < NUM_BIAS; i++) begin
                bias_act_d[i] = preset_en_q ? rom_bias[i] : bias_sh_q[i];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_COEF; i++) begin
            if (i_rd_addr == 4'(i)) rd_data_d = WDATA_WIDTH'(coef_sh_q[i]);
        end
        for (int unsigned i = 0; i < NUM_BIAS; i++) begin
            if (i_rd_addr == 4'(ADDR_BIAS_FIRST + i)) rd_data_d = WDATA_WIDTH'(bias_sh_q[i]);
        end
        if (i_rd_addr == ADDR_CTRL) begin
            rd_data_d[CTRL_BYPASS_BIT]    = bypass_sh_q;
            rd_data_d[CTRL_PRESET_EN_BIT] = preset_en_q;
            rd_data_d[CTRL_PRESET_ID_BIT] = preset_id_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            vs_dly_q     <= 1'b0;
            update_q     <= 1'b0;
            rd_data_q    <= '0;
            coef_sh_q    <= '{default: '0};
            bias_sh_q    <= '{default: '0};
            bypass_sh_q  <= 1'b1;
            preset_en_q  <= 1'b0;
            preset_id_q  <= 1'b0;
            coef_act_q   <= '{default: '0};
            bias_act_q   <= '{default: '0};
            bypass_act_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            vs_dly_q     <= vs_dly_d;
            update_q     <= update_d;
            rd_data_q    <= rd_data_d;
            coef_sh_q    <= coef_sh_d;
            bias_sh_q    <= bias_sh_d;
            bypass_sh_q  <= bypass_sh_d;
            preset_en_q  <= preset_en_d;
            preset_id_q  <= preset_id_d;
            coef_act_q   <= coef_act_d;
            bias_act_q   <= bias_act_d;
            bypass_act_q <= bypass_act_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_pending = (state_q == ST_PENDING);
    assign o_update  = update_q;
    assign o_bypass  = bypass_act_q;
    assign o_coef00  = coef_act_q[0];
    assign o_coef01  = coef_act_q[1];
    assign o_coef02  = coef_act_q[2];
    assign o_coef10  = coef_act_q[3];
    assign o_coef11  = coef_act_q[4];
    assign o_coef12  = coef_act_q[5];
    assign o_coef20  = coef_act_q[6];
    assign o_coef21  = coef_act_q[7];
    assign o_coef22  = coef_act_q[8];
    assign o_bias0   = bias_act_q[0];
    assign o_bias1   = bias_act_q[1];
    assign o_bias2   = bias_act_q[2];

endmodule

// File: tb/tb_csc_coef_ctrl.sv
// Directed self-checking bench for csc_coef_ctrl: writes, readback, commit
// timing against vsync, presets and reset while a commit is armed.
module tb_csc_coef_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_wr_en;
    logic [3:0]  i_wr_addr;
    logic [15:0] i_wr_data;
    logic [3:0]  i_rd_addr;
    logic [15:0] o_rd_data;
    logic        i_commit;
    logic        i_vs;
    logic        o_pending;
    logic        o_update;
    logic        o_bypass;
    logic signed [9:0] o_coef00, o_coef01, o_coef02;
    logic signed [9:0] o_coef10, o_coef11, o_coef12;
    logic signed [9:0] o_coef20, o_coef21, o_coef22;
    logic signed [7:0] o_bias0, o_bias1, o_bias2;

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;
    int upd_snap;

    csc_coef_ctrl #(
        .COEF_WIDTH  (10),
        .BIAS_WIDTH  (8),
        .WDATA_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data),
        .i_commit  (i_commit),
        .i_vs      (i_vs),
        .o_pending (o_pending),
        .o_update  (o_update),
        .o_bypass  (o_bypass),
        .o_coef00  (o_coef00),
        .o_coef01  (o_coef01),
        .o_coef02  (o_coef02),
        .o_coef10  (o_coef10),
        .o_coef11  (o_coef11),
        .o_coef12  (o_coef12),
        .o_coef20  (o_coef20),
        .o_coef21  (o_coef21),
        .o_coef22  (o_coef22),
        .o_bias0   (o_bias0),
        .o_bias1   (o_bias1),
        .o_bias2   (o_bias2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn === 1'b1 && o_update === 1'b1) upd_cnt++;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic commit();
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
    endtask

    task automatic vs_pulse();
        i_vs = 1'b1;
        tick();
        i_vs = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        i_rd_addr = '0; i_commit = 1'b0; i_vs = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset state
        check("rst_bypass",  o_bypass,  1);
        check("rst_coef00",  o_coef00,  0);
        check("rst_coef22",  o_coef22,  0);
        check("rst_bias2",   o_bias2,   0);
        check("rst_pending", o_pending, 0);
        check("rst_update",  o_update,  0);
        check("rst_rd_data", o_rd_data, 0);
        vs_pulse();
        check("idle_vs_no_update", upd_cnt, 0);
        check("idle_vs_bypass",    o_bypass, 1);

        // Manual coefficients applied at vsync rise
        wr(4'd0, 16'd100);
        wr(4'd12, 16'd0);
        commit();
        check("commit_pending",   o_pending, 1);
        check("pre_vs_coef00",    o_coef00,  0);
        check("pre_vs_bypass",    o_bypass,  1);
        repeat (2) tick();
        check("pre_vs_hold",      o_coef00,  0);
        i_vs = 1'b1;
        tick();
        check("apply_update",     o_update,  1);
        check("apply_coef00",     o_coef00,  100);
        check("apply_bypass",     o_bypass,  0);
        check("apply_pending",    o_pending, 0);
        i_vs = 1'b0;
        tick();
        check("update_one_cycle", o_update,  0);
        check("update_count1",    upd_cnt,   1);

        // BT.709 preset
        wr(4'd12, 16'h0006);
        commit();
        vs_pulse();
        check("bt709_coef00", o_coef00, 109);
        check("bt709_coef01", o_coef01, 366);
        check("bt709_coef10", o_coef10, -59);
        check("bt709_coef12", o_coef12, 256);
        check("bt709_coef21", o_coef21, -233);
        check("bt709_coef22", o_coef22, -23);
        check("bt709_bias0",  o_bias0,  0);
        check("bt709_bypass", o_bypass, 0);

        // BT.601 preset
        wr(4'd12, 16'h0002);
        commit();
        vs_pulse();
        check("bt601_coef00", o_coef00, 153);
        check("bt601_coef11", o_coef11, -170);
        check("bt601_coef21", o_coef21, -214);
        check("bt601_coef22", o_coef22, -42);

        // Readback: sign extension, control zero extension, reserved
        wr(4'd4, 16'hFFFB);
        wr(4'd9, 16'h00FD);
        wr(4'd13, 16'h1234);
        i_rd_addr = 4'd4;  tick();
        check("rd_coef11_neg",  o_rd_data, 32'hFFFB);
        i_rd_addr = 4'd14; tick();
        check("rd_reserved14",  o_rd_data, 0);
        i_rd_addr = 4'd9;  tick();
        check("rd_bias0_neg",   o_rd_data, 32'hFFFD);
        i_rd_addr = 4'd12; tick();
        check("rd_ctrl",        o_rd_data, 2);
        i_rd_addr = 4'd0;  tick();
        check("rd_coef00",      o_rd_data, 100);
        i_rd_addr = 4'd13; tick();
        check("rd_reserved13",  o_rd_data, 0);
        check("shadow_not_active", o_coef11, -170);

        // Writes while pending are included; write in apply cycle is not
        commit();
        commit();
        check("pending_recommit", o_pending, 1);
        wr(4'd12, 16'h0000);
        i_vs = 1'b1; i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = 16'd77;
        tick();
        i_wr_en = 1'b0;
        check("wa_update", o_update, 1);
        check("wa_coef00", o_coef00, 100);
        check("wa_coef11", o_coef11, -5);
        check("wa_bias0",  o_bias0,  -3);
        check("wa_bypass", o_bypass, 0);
        i_vs = 1'b0; i_rd_addr = 4'd0;
        tick();
        tick();
        check("wa_shadow_rd", o_rd_data, 77);

        // Commit coincident with vsync rise waits one frame
        wr(4'd0, 16'd5);
        i_commit = 1'b1; i_vs = 1'b1;
        tick();
        i_commit = 1'b0;
        check("coinc_no_update", o_update,  0);
        check("coinc_pending",   o_pending, 1);
        check("coinc_coef00",    o_coef00,  100);
        i_vs = 1'b0; tick();
        i_vs = 1'b1; tick();
        check("coinc_next_update", o_update, 1);
        check("coinc_next_coef00", o_coef00, 5);
        i_vs = 1'b0; tick();
        check("update_count5", upd_cnt, 5);

        // Reset while pending discards the commit
        wr(4'd0, 16'd33);
        wr(4'd12, 16'd0);
        commit();
        check("prerst_pending", o_pending, 1);
        upd_snap = upd_cnt;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("rstpend_pending", o_pending, 0);
        vs_pulse();
        vs_pulse();
        check("rstpend_no_update", upd_cnt - upd_snap, 0);
        check("rstpend_coef00",    o_coef00, 0);
        check("rstpend_bypass",    o_bypass, 1);
        check("rstpend_pending2",  o_pending, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
